// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants for the RV32I front end.
// IFETCH_MISALIGN_EN adds a misaligned flag to the buffered fetch entry.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_LSB = 0;
  localparam int unsigned OP_MSB = 6;
  localparam int unsigned F3_LSB = 12;
  localparam int unsigned F3_MSB = 14;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;
  localparam int unsigned F3_W   = F3_MSB - F3_LSB + 1;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
`ifdef IFETCH_MISALIGN_EN
    logic            misaligned;
`endif
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: power-of-two sync FIFO of fetch entries with flush.
// A flush may coincide with a push; the pushed entry becomes the only entry.
module ifetch_fifo
  import core_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  // Pop is ignored on flush; push into a full buffer only alongside a pop.
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      count  <= CW'(push);
      if (push) begin
        mem[0] <= wdata;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, redirect drain.
// Optional IFETCH_MISALIGN_EN: misaligned redirect targets yield one flagged nop entry.
module ifetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [31:0]     imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [31:0]     id_pc,
  output logic [31:0]     id_pc_plus4,
  output logic [OP_W-1:0] id_op,
  output logic [F3_W-1:0] id_funct3
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic            id_misaligned
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   resp_pc;
  logic [31:0]   resp_pc_next;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard;
  logic [CW-1:0] discard_next;
  logic          halt;
  logic          halt_next;

  logic          redirect_take;
  logic          misalign_hit;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_take;
  logic          fifo_flush;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  fetch_entry_t  head_vis;

  assign redirect_take = redirect_valid && (state != BOOT);
`ifdef IFETCH_MISALIGN_EN
  assign misalign_hit  = redirect_take && (redirect_pc[1:0] != 2'b00);
`else
  assign misalign_hit  = 1'b0;
`endif

  // In-flight plus buffered instructions never exceed the buffer depth.
  assign credit_ok      = ((CW+1)'(outstanding) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = (state == RUN) && !halt && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding (e.g. leftovers from before reset) are ignored.
  assign rsp_take       = imem_rsp_valid && (outstanding != '0);

  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    resp_pc_next     = resp_pc;
    outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_take);
    discard_next     = discard;
    halt_next        = halt;
    fifo_flush       = 1'b0;
    fifo_push        = 1'b0;
    push_entry       = '0;
    push_entry.pc    = resp_pc;
    push_entry.instr = imem_rsp_data;

    if (req_fire) begin
      fetch_pc_next = fetch_pc + PC_STEP;
    end

    // Redirect wins: flush, reload both PCs, drop everything still in flight.
    if (redirect_take) begin
      fifo_flush    = 1'b1;
      fetch_pc_next = redirect_pc & WORD_MASK;
      resp_pc_next  = redirect_pc & WORD_MASK;
      discard_next  = outstanding_next;
      halt_next     = misalign_hit;
      if (misalign_hit) begin
        fifo_push        = 1'b1;
        push_entry.pc    = redirect_pc;
        push_entry.instr = NOP_INSTR;
`ifdef IFETCH_MISALIGN_EN
        push_entry.misaligned = 1'b1;
`endif
      end
    end else if (rsp_take) begin
      if (discard != '0) begin
        discard_next = discard - CW'(1);
      end else begin
        fifo_push    = 1'b1;
        resp_pc_next = resp_pc + PC_STEP;
      end
    end

    case (state)
      BOOT:       state_next = RUN;
      RUN, DRAIN: state_next = (discard_next != '0) ? DRAIN : RUN;
      default:    state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      halt        <= 1'b0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      resp_pc     <= resp_pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      halt        <= halt_next;
    end
  end

  assign fifo_pop = id_valid && id_ready;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .count (fifo_count)
  );

  // Decode sees zeros whenever the buffer is empty.
  assign id_valid    = (fifo_count != '0);
  assign head_vis    = id_valid ? head : '0;
  assign id_instr    = head_vis.instr;
  assign id_pc       = head_vis.pc;
  assign id_pc_plus4 = id_valid ? (head_vis.pc + PC_STEP) : '0;
  assign id_op       = head_vis.instr[OP_MSB:OP_LSB];
  assign id_funct3   = head_vis.instr[F3_MSB:F3_LSB];
`ifdef IFETCH_MISALIGN_EN
  assign id_misaligned = head_vis.misaligned;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a one-cycle in-order instruction memory.
module tb_ifetch_unit;

  localparam int unsigned FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [6:0]  id_op;
  logic [2:0]  id_funct3;
`ifdef IFETCH_MISALIGN_EN
  logic        id_misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic        rsp_en;
  logic [31:0] pend[$];
  logic [31:0] hs_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_ins_q[$];
  logic [6:0]  pop_op_q[$];
  logic [2:0]  pop_f3_q[$];

  ifetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_op          (id_op),
    .id_funct3      (id_funct3)
`ifdef IFETCH_MISALIGN_EN
    ,
    .id_misaligned  (id_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0] ^ a[31:16];
    return {16'hC0DE, (lo << 10) ^ lo ^ 16'h3033};
  endfunction

  // Buffer must never be pushed while full without a same-cycle pop.
  always @(negedge clk) begin
    if (rst_n) begin
      check("fifo_overflow",
            32'(dut.u_fifo.push && !dut.u_fifo.flush && !dut.u_fifo.do_pop &&
                (32'(dut.u_fifo.count) == FIFO_DEPTH)), 32'd0);
    end
  end

  task automatic clear_logs();
    hs_q.delete();
    pop_pc_q.delete();
    pop_ins_q.delete();
    pop_op_q.delete();
    pop_f3_q.delete();
  endtask

  // One clock: sample handshakes before the edge, drive memory response after it.
  task automatic tick();
    logic        hs;
    logic        pp;
    logic [31:0] ha;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [6:0]  op;
    logic [2:0]  f3;
    #1;
    hs  = imem_req_valid && imem_req_ready;
    ha  = imem_req_addr;
    pp  = id_valid && id_ready && !redirect_valid;
    pc  = id_pc;
    ins = id_instr;
    op  = id_op;
    f3  = id_funct3;
    @(posedge clk);
    if (hs) begin
      pend.push_back(ha);
      hs_q.push_back(ha);
    end
    if (pp) begin
      pop_pc_q.push_back(pc);
      pop_ins_q.push_back(ins);
      pop_op_q.push_back(op);
      pop_f3_q.push_back(f3);
    end
    #1;
    if (rsp_en && pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut(input bit keep_pend);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!keep_pend) pend.delete();
    clear_logs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    rsp_en         = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr",  imem_req_addr,       32'h0);
    check("rst_id_valid",  32'(id_valid),       32'd0);
    check("rst_id_instr",  id_instr,            32'h0);
    check("rst_id_pc",     id_pc,               32'h0);
    check("rst_id_pc4",    id_pc_plus4,         32'h0);
    check("rst_id_op",     32'(id_op),          32'd0);
    check("rst_id_f3",     32'(id_funct3),      32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Streaming with zero-wait memory and decode always ready
    ticks(12);
    check("t1_npops", 32'(pop_pc_q.size() >= 3), 32'd1);
    check("t1_req0",  hs_q[0], 32'h0);
    check("t1_req1",  hs_q[1], 32'h4);
    check("t1_req2",  hs_q[2], 32'h8);
    check("t1_pc0",   pop_pc_q[0], 32'h0);
    check("t1_pc1",   pop_pc_q[1], 32'h4);
    check("t1_pc2",   pop_pc_q[2], 32'h8);
    check("t1_ins0",  pop_ins_q[0], 32'hC0DE_3033);
    check("t1_op0",   32'(pop_op_q[0]), 32'h33);
    check("t1_op1",   32'(pop_op_q[1]), 32'h37);
    check("t1_op2",   32'(pop_op_q[2]), 32'h3B);
    check("t1_f30",   32'(pop_f3_q[0]), 32'd3);
    check("t1_f31",   32'(pop_f3_q[1]), 32'd2);
    check("t1_f32",   32'(pop_f3_q[2]), 32'd1);

    // Address wrap at the top of the 32-bit space
    redirect_to(32'hFFFF_FFF8);
    ticks(14);
    check("wrap_req0", hs_q[0], 32'hFFFF_FFF8);
    check("wrap_req1", hs_q[1], 32'hFFFF_FFFC);
    check("wrap_req2", hs_q[2], 32'h0000_0000);
    check("wrap_pc1",  pop_pc_q[1], 32'hFFFF_FFFC);
    check("wrap_pc2",  pop_pc_q[2], 32'h0000_0000);

    // Decode backpressure: credit limits requests to the buffer depth
    reset_dut(1'b0);
    id_ready = 1'b0;
    ticks(8);
    #1;
    check("bp_nreq",     32'(hs_q.size()),   32'd2);
    check("bp_req_idle", 32'(imem_req_valid), 32'd0);
    check("bp_id_valid", 32'(id_valid),       32'd1);
    check("bp_id_pc",    id_pc,               32'h0);
    id_ready = 1'b1;
    tick();
    check("bp_nreq_a",  32'(hs_q.size()),     32'd2);
    check("bp_npop_a",  32'(pop_pc_q.size()), 32'd1);
    rsp_en = 1'b0;
    tick();
    check("bp_nreq_b",  32'(hs_q.size()),     32'd3);
    check("bp_npop_b",  32'(pop_pc_q.size()), 32'd2);
    check("bp_req2",    hs_q[2],              32'h8);

    // Stale response after reset is ignored; request address holds under stall
    reset_dut(1'b1);
    rsp_en         = 1'b1;
    id_ready       = 1'b0;
    imem_req_ready = 1'b1;
    ticks(2);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr",  imem_req_addr,       32'h4);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    #1;
    check("stall_nreq",   32'(hs_q.size()), 32'd2);
    check("stall_req1",   hs_q[1],          32'h4);
    check("stall_next",   imem_req_addr,    32'h8);
    check("stale_pc",     id_pc,            32'h0);
    check("stale_instr",  id_instr,         32'hC0DE_3033);
    check("stale_pc4",    id_pc_plus4,      32'h4);
    check("stale_op",     32'(id_op),       32'h33);
    check("stale_f3",     32'(id_funct3),   32'd3);

    // Redirect with two outstanding requests: drain both stale responses
    reset_dut(1'b0);
    rsp_en   = 1'b0;
    id_ready = 1'b1;
    ticks(3);
    #1;
    check("dr_credit", 32'(imem_req_valid), 32'd0);
    rsp_en = 1'b1;
    redirect_to(32'h100);
    #1;
    check("dr_idv0", 32'(id_valid),       32'd0);
    check("dr_req0", 32'(imem_req_valid), 32'd0);
    tick();
    #1;
    check("dr_idv1", 32'(id_valid),       32'd0);
    check("dr_req1", 32'(imem_req_valid), 32'd0);
    tick();
    #1;
    check("dr_resume", 32'(imem_req_valid), 32'd1);
    check("dr_addr",   imem_req_addr,        32'h100);
    ticks(6);
    check("dr_pc0",  pop_pc_q[0],  32'h100);
    check("dr_ins0", pop_ins_q[0], 32'hC0DE_3133);
    check("dr_pc1",  pop_pc_q[1],  32'h104);

    // Redirect coincident with a response and a pop
    reset_dut(1'b0);
    id_ready = 1'b1;
    ticks(3);
    #1;
    check("co_pre_idv", 32'(id_valid), 32'd1);
    redirect_to(32'h200);
    #1;
    check("co_idv",  32'(id_valid),       32'd0);
    check("co_req",  32'(imem_req_valid), 32'd1);
    check("co_addr", imem_req_addr,       32'h200);
    ticks(8);
    check("co_npops", 32'(pop_pc_q.size() >= 2), 32'd1);
    check("co_ins0",  pop_ins_q[0], 32'hC0DE_3233);
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      check("co_seq", pop_pc_q[i], 32'h200 + 32'(4 * i));
    end

`ifdef IFETCH_MISALIGN_EN
    // Misaligned target: one flagged nop, fetch halted until the next redirect
    reset_dut(1'b0);
    id_ready = 1'b0;
    ticks(6);
    redirect_to(32'h102);
    #1;
    check("mis_idv",   32'(id_valid),       32'd1);
    check("mis_instr", id_instr,            32'h0000_0013);
    check("mis_pc",    id_pc,               32'h102);
    check("mis_pc4",   id_pc_plus4,         32'h106);
    check("mis_flag",  32'(id_misaligned),  32'd1);
    check("mis_req",   32'(imem_req_valid), 32'd0);
    id_ready = 1'b1;
    ticks(5);
    check("mis_npop",  32'(pop_pc_q.size()), 32'd1);
    check("mis_nreq",  32'(hs_q.size()),     32'd0);
    check("mis_idv2",  32'(id_valid),        32'd0);
    redirect_to(32'h40);
    ticks(4);
    check("mis_req40", hs_q[0],     32'h40);
    check("mis_pc40",  pop_pc_q[0], 32'h40);
    check("mis_flag0", 32'(id_misaligned), 32'd0);
`else
    // Low target bits are dropped when misalign reporting is absent
    reset_dut(1'b0);
    id_ready = 1'b1;
    ticks(3);
    redirect_to(32'h10A);
    ticks(6);
    check("al_req0", hs_q[0],     32'h108);
    check("al_pc0",  pop_pc_q[0], 32'h108);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
